// File: rtl/c2h_tx_pkg.sv
// Shared types and constants for the C2H frame transmitter.
package c2h_tx_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR_RD,
        ST_HDR_CAP,
        ST_DAT_RD,
        ST_DAT_CAP,
        ST_LO,
        ST_HI,
        ST_IRQ,
        ST_DONE
    } tx_state_e;

    localparam int LEN_LSB        = 0;
    localparam int LEN_W          = 16;
    localparam int DEF_SLOT_WORDS = 64;

    // Largest payload that fits behind the header word of one slot.
    function automatic logic [LEN_W-1:0] max_len(input int slot_words);
        return LEN_W'((slot_words - 1) * 16);
    endfunction

endpackage

// File: rtl/c2h_frame_tx_rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(ptr) + i) % N);
            if (!gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/c2h_frame_tx.sv
// Streams ready frames from the 128-bit buffer RAM onto XDMA C2H channel 0,
// two 64-bit beats per word, with optional per-frame MSI and slot release.
module c2h_frame_tx
    import c2h_tx_pkg::*;
#(
    parameter int SLOTS      = 8,
    parameter int SLOT_WORDS = DEF_SLOT_WORDS,
    parameter int ADDR_W     = 32,
    parameter int IRQ_VEC    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SLOTS-1:0]  slot_ready,
    output logic [SLOTS-1:0]  slot_done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [127:0]      rd_data,
    output logic [63:0]       s_axis_c2h_tdata_0,
    output logic [7:0]        s_axis_c2h_tkeep_0,
    output logic              s_axis_c2h_tlast_0,
    output logic              s_axis_c2h_tvalid_0,
    input  logic              s_axis_c2h_tready_0,
    output logic [15:0]       usr_irq_req,
    input  logic [15:0]       usr_irq_ack,
    input  logic              msi_enable
);

    localparam int               IDX_W   = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN = max_len(SLOT_WORDS);
    localparam logic [LEN_W:0]   B_ONE   = 1;
    localparam logic [LEN_W:0]   B_SEVEN = 7;

    tx_state_e         state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d, ptr_q, ptr_d, gnt_idx;
    logic              gnt_vld;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d, beat_q, beat_d, hdr_len;
    logic [127:0]      word_q, word_d;
    logic              irq_q, irq_d;
    logic [SLOTS-1:0]  done_q, done_d;
    logic [LEN_W:0]    n_beats;
    logic              last_beat, tvalid, unused_ack;
    logic [7:0]        keep_last;

    // done_q hides a just-released slot whose ready flag is still up.
    rr_arbiter #(.N(SLOTS), .IW(IDX_W)) u_arb (
        .req     (slot_ready & ~done_q),
        .ptr     (ptr_q),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign hdr_len    = rd_data[LEN_LSB +: LEN_W];
    assign n_beats    = ({1'b0, len_q} + B_SEVEN) >> 3;
    assign last_beat  = ({1'b0, beat_q} + B_ONE) == n_beats;
    assign keep_last  = (len_q[2:0] == 3'd0) ? 8'hFF : (8'hFF >> (4'd8 - {1'b0, len_q[2:0]}));
    assign unused_ack = ^usr_irq_ack;

    assign tvalid              = (state_q == ST_LO) || (state_q == ST_HI);
    assign s_axis_c2h_tvalid_0 = tvalid;
    assign s_axis_c2h_tdata_0  = (state_q == ST_HI) ? word_q[127:64] : word_q[63:0];
    assign s_axis_c2h_tlast_0  = tvalid && last_beat;
    assign s_axis_c2h_tkeep_0  = !tvalid ? 8'h00 : (last_beat ? keep_last : 8'hFF);

    always_comb begin
        usr_irq_req          = '0;
        usr_irq_req[IRQ_VEC] = irq_q;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        base_d    = base_q;
        len_d     = len_q;
        beat_d    = beat_q;
        word_d    = word_q;
        irq_d     = irq_q;
        rd_en     = 1'b0;
        rd_addr   = '0;
        slot_done = '0;
        unique case (state_q)
            ST_IDLE: if (gnt_vld) begin
                idx_d   = gnt_idx;
                base_d  = ADDR_W'(gnt_idx) * ADDR_W'(SLOT_WORDS);
                ptr_d   = (gnt_idx == IDX_W'(SLOTS - 1)) ? '0 : gnt_idx + IDX_W'(1);
                beat_d  = '0;
                state_d = ST_HDR_RD;
            end
            ST_HDR_RD: begin
                rd_en   = 1'b1;
                rd_addr = base_q;
                state_d = ST_HDR_CAP;
            end
            ST_HDR_CAP: begin
                len_d   = (hdr_len > MAX_LEN) ? MAX_LEN : hdr_len;
                beat_d  = '0;
                state_d = (hdr_len == '0) ? ST_DONE : ST_DAT_RD;
            end
            ST_DAT_RD: begin
                rd_en   = 1'b1;
                rd_addr = base_q + ADDR_W'(beat_q >> 1) + ADDR_W'(1);
                state_d = ST_DAT_CAP;
            end
            ST_DAT_CAP: begin
                word_d  = rd_data;
                state_d = ST_LO;
            end
            ST_LO, ST_HI: if (s_axis_c2h_tready_0) begin
                if (last_beat) begin
                    irq_d   = msi_enable;
                    state_d = ST_IRQ;
                end else begin
                    beat_d  = beat_q + LEN_W'(1);
                    state_d = (state_q == ST_LO) ? ST_HI : ST_DAT_RD;
                end
            end
            ST_IRQ: begin
                if (!irq_q) begin
                    state_d = ST_DONE;
                end else if (usr_irq_ack[IRQ_VEC]) begin
                    irq_d   = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                slot_done[idx_q] = 1'b1;
                state_d          = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        done_d = slot_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            base_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            word_q  <= '0;
            irq_q   <= 1'b0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            base_q  <= base_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            word_q  <= word_d;
            irq_q   <= irq_d;
            done_q  <= done_d;
        end
    end

endmodule
